// File: rtl/pipeline_exec_ctrl.sv
// pipeline_exec_ctrl: debug run/step/halt controller that gates the pipeline enable and counts executed cycles
module pipeline_exec_ctrl #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_cmd_valid,
  input  logic [1:0]           i_cmd,
  output logic                 o_cmd_ready,
  input  logic                 i_halt,
  output logic                 o_enable,
  output logic [1:0]           o_state,
  output logic [CNT_WIDTH-1:0] o_cycle_cnt,
  output logic                 o_done
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, STEP = 2'b10, HALTED = 2'b11} state_t;
  localparam logic [1:0] C_CLEAR = 2'b00;
  localparam logic [1:0] C_RUN   = 2'b01;
  localparam logic [1:0] C_STEP  = 2'b10;
  localparam logic [1:0] C_STOP  = 2'b11;
  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic                 acc, clr;
  assign o_enable    = (state_q == RUN) || (state_q == STEP);
  assign o_cmd_ready = state_q != STEP;
  assign o_state     = state_q;
  assign o_cycle_cnt = cnt_q;
  assign o_done      = done_q;
  assign acc         = i_cmd_valid && o_cmd_ready;
  assign clr         = acc && i_cmd == C_CLEAR && (state_q == IDLE || state_q == HALTED);
  // next state: halt outranks STOP in RUN; halt is only seen while enabled
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (acc && i_cmd == C_RUN) ? RUN : (acc && i_cmd == C_STEP) ? STEP : IDLE;
      RUN:     state_d = i_halt ? HALTED : (acc && i_cmd == C_STOP) ? IDLE : RUN;
      STEP:    state_d = i_halt ? HALTED : IDLE;
      HALTED:  state_d = (acc && i_cmd == C_CLEAR) ? IDLE : HALTED;
      default: state_d = IDLE;
    endcase
  end
  // saturating enabled-cycle counter and one-cycle done pulse on HALTED entry
  always_comb begin
    cnt_d  = clr ? '0 : (o_enable && cnt_q != '1) ? cnt_q + CNT_WIDTH'(1) : cnt_q;
    done_d = state_d == HALTED && state_q != HALTED;
  end
  // state registers with asynchronous clear
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end
endmodule
